// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size and state encodings shared by the load/store unit.
package mem_access_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) || (size == SIZE_H && off[0]) || (size == SIZE_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane merge for sub-word stores and lane extraction for loads.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        if (sz == SIZE_B)
            r[{off, 3'b000} +: 8] = wd[7:0];
        else if (sz == SIZE_H)
            r[{off[1], 4'b0000} +: 16] = wd[15:0];
        else
            r = wd;
        return r;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] off, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        return sz == SIZE_B ? {{24{b[7] & ~u}}, b} :
               sz == SIZE_H ? {{16{h[15] & ~u}}, h} : w;
    endfunction

    assign merged    = merge_store(old_word, wdata, size, offset);
    assign load_data = extract_load(rd_word, size, offset, uns);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end; sub-word stores run as read-modify-write
// because the data memory only has a whole-word write enable.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [31:0]           mem_d,
    output logic                  mem_we,
    input  logic [31:0]           mem_spo
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  we_q, we_d;
    logic                  uns_q, uns_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           word_q, word_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [31:0]           merged, load_data;
    logic                  accept;

    mem_lane_align u_align (
        .old_word (word_q),
        .wdata    (wdata_q),
        .rd_word  (mem_spo),
        .size     (size_q),
        .offset   (addr_q[1:0]),
        .uns      (uns_q),
        .merged   (merged),
        .load_data(load_data)
    );

    assign req_ready  = state_q == ST_IDLE;
    assign accept     = req_valid && req_ready;
    assign mem_a      = addr_q[ADDR_WIDTH+1:2];
    assign mem_d      = merged;
    assign mem_we     = state_q == ST_WRITE;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        we_d         = we_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                addr_d  = req_addr;
                size_d  = req_size;
                we_d    = req_we;
                uns_d   = req_unsigned;
                wdata_d = req_wdata;
                if (misaligned(req_size, req_addr[1:0])) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b1;
                end else begin
                    state_d = (req_we && req_size == SIZE_W) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                word_d  = mem_spo;
                state_d = we_q ? ST_WRITE : ST_IDLE;
                if (!we_q) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                    resp_err_d   = 1'b0;
                end
            end
            ST_WRITE: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= 32'h0;
            word_q       <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed requests against a word-array model of the memory,
// with a per-cycle compare of every DUT output against the model's predictions.
module tb_mem_access_unit;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0, req_we = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [11:0] req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_d, mem_spo;
    logic [9:0]  mem_a;

    mem_access_unit #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_a(mem_a), .mem_d(mem_d),
        .mem_we(mem_we), .mem_spo(mem_spo)
    );

    always #5 clk = ~clk;

    // data memory: single-cycle write, or pipeline mode with a one-cycle write delay plus forwarding
    logic [31:0] mem [0:1023];
    bit          pipe_mode = 0;
    logic        pend_v;
    logic [9:0]  pend_a;
    logic [31:0] pend_d;
    assign mem_spo = (pipe_mode && pend_v && pend_a == mem_a) ? pend_d : mem[mem_a];
    always @(posedge clk) begin
        if (rst) pend_v <= 1'b0;
        else if (pipe_mode) begin
            if (pend_v) mem[pend_a] <= pend_d;
            pend_v <= mem_we;
            pend_a <= mem_a;
            pend_d <= mem_d;
        end else if (mem_we) mem[mem_a] <= mem_d;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // model: expected outputs indexed by cycle number
    logic [31:0] mdl [0:1023];
    bit          e_rv [0:4095];
    bit          e_er [0:4095];
    bit          e_busy [0:4095];
    bit          e_we [0:4095];
    logic [31:0] e_rd [0:4095];
    logic [31:0] e_wd [0:4095];
    logic [9:0]  e_wa [0:4095];
    int          last_idx;
    logic [31:0] last_old;

    task automatic flush();
        for (int i = 0; i < 4096; i++) begin
            e_rv[i] = 0; e_er[i] = 0; e_busy[i] = 0; e_we[i] = 0;
        end
    endtask

    task automatic model(input int k, input bit we, input logic [1:0] sz, input bit un,
                         input logic [11:0] a, input logic [31:0] wd);
        int idx, sh, wc;
        longint lm;
        logic [31:0] m, v;
        idx = int'(a) / 4;
        sh = 8 * (int'(a) % 4);
        lm = sz == 0 ? 64'hFF : sz == 1 ? 64'hFFFF : 64'hFFFF_FFFF;
        m = 32'(lm << sh);
        if (sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)) begin
            e_rv[k] = 1; e_er[k] = 1; e_rd[k] = 0;
        end else if (!we) begin
            v = (mdl[idx] & m) >> sh;
            if (!un && sz != 2 && v[sz == 0 ? 7 : 15]) v = v | ~32'(lm);
            e_busy[k] = 1;
            e_rv[k+1] = 1; e_er[k+1] = 0; e_rd[k+1] = v;
        end else begin
            wc = sz == 2 ? k : k + 1;
            for (int c = k; c <= wc; c++) e_busy[c] = 1;
            last_idx = idx;
            last_old = mdl[idx];
            mdl[idx] = (mdl[idx] & ~m) | ((wd << sh) & m);
            e_we[wc] = 1; e_wa[wc] = 10'(idx); e_wd[wc] = mdl[idx];
            e_rv[wc+1] = 1; e_er[wc+1] = 0; e_rd[wc+1] = 0;
        end
    endtask

    logic [31:0] hold_rd = 0;
    logic        hold_er = 0;
    always @(negedge clk) begin
        if (e_rv[cyc]) begin
            hold_rd = e_rd[cyc];
            hold_er = e_er[cyc];
        end
        if (rst) begin
            hold_rd = 0;
            hold_er = 0;
        end
        chk("resp_valid", resp_valid, e_rv[cyc]);
        chk("resp_rdata", resp_rdata, hold_rd);
        chk("resp_err", resp_err, hold_er);
        chk("req_ready", req_ready, !e_busy[cyc]);
        chk("mem_we", mem_we, e_we[cyc]);
        if (e_we[cyc]) begin
            chk("mem_a", mem_a, e_wa[cyc]);
            chk("mem_d", mem_d, e_wd[cyc]);
        end
    end

    // results of the last transaction as seen on the DUT pins
    logic [31:0] r_rd, r_wd;
    logic [9:0]  r_wa;
    bit          r_er;
    int          r_lat, r_nwr, r_wl, r_k;

    task automatic issue(input bit we, input logic [1:0] sz, input bit un,
                         input logic [11:0] a, input logic [31:0] wd);
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        r_k = cyc;
        req_valid = 0;
        model(r_k, we, sz, un, a, wd);
    endtask

    task automatic xact(input bit we, input logic [1:0] sz, input bit un,
                        input logic [11:0] a, input logic [31:0] wd);
        bit got;
        issue(we, sz, un, a, wd);
        got = 0; r_nwr = 0; r_lat = 0; r_wl = 0; r_rd = 0; r_er = 0; r_wd = 0; r_wa = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (mem_we) begin
                r_nwr++; r_wl = cyc - r_k + 1; r_wd = mem_d; r_wa = mem_a;
            end
            if (resp_valid) begin
                got = 1; r_lat = cyc - r_k + 1; r_rd = resp_rdata; r_er = resp_err;
            end
        end
        chk("resp_timeout", got, 1);
    endtask

    task automatic run(input string nm, input bit we, input logic [1:0] sz, input bit un,
                       input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] x_rd, input bit x_er, input int x_lat);
        xact(we, sz, un, a, wd);
        chk({nm, "_rdata"}, r_rd, x_rd);
        chk({nm, "_err"}, r_er, x_er);
        chk({nm, "_latency"}, r_lat, x_lat);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mdl[i] = 0;
        flush();
        repeat (3) @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("reset_ready", req_ready, 1);
        chk("reset_resp_valid", resp_valid, 0);

        run("setup_word_store", 1, 2'b10, 0, 12'h010, 32'h8899AABB, 32'h0, 0, 2);
        chk("setup_write_cycle", r_wl, 1);
        run("byte_load_signed", 0, 2'b00, 0, 12'h011, 32'h0, 32'hFFFFFFAA, 0, 2);
        chk("byte_load_no_write", r_nwr, 0);
        run("half_load_unsigned", 0, 2'b01, 1, 12'h012, 32'h0, 32'h00008899, 0, 2);
        run("byte_store_rmw", 1, 2'b00, 0, 12'h013, 32'h12345677, 32'h0, 0, 3);
        chk("rmw_write_count", r_nwr, 1);
        chk("rmw_write_cycle", r_wl, 2);
        chk("rmw_mem_a", r_wa, 10'd4);
        chk("rmw_mem_d", r_wd, 32'h7799AABB);
        run("rmw_readback", 0, 2'b10, 0, 12'h010, 32'h0, 32'h7799AABB, 0, 2);
        run("misaligned_store", 1, 2'b10, 0, 12'h012, 32'hFFFFFFFF, 32'h0, 1, 1);
        chk("misaligned_no_write", r_nwr, 0);
        chk("misaligned_mem_kept", mem[4], 32'h7799AABB);
        run("half_load_signed", 0, 2'b01, 0, 12'h010, 32'h0, 32'hFFFFAABB, 0, 2);
        run("byte_load_unsigned", 0, 2'b00, 1, 12'h010, 32'h0, 32'h000000BB, 0, 2);
        run("word_load_uns_ignored", 0, 2'b10, 1, 12'h010, 32'h0, 32'h7799AABB, 0, 2);
        run("illegal_size", 0, 2'b11, 0, 12'h010, 32'h0, 32'h0, 1, 1);
        run("odd_half_load", 0, 2'b01, 0, 12'h011, 32'h0, 32'h0, 1, 1);
        run("b2b_store", 1, 2'b10, 0, 12'h020, 32'hDEADBEEF, 32'h0, 0, 2);
        run("b2b_load", 0, 2'b10, 0, 12'h020, 32'h0, 32'hDEADBEEF, 0, 2);
        run("half_store_upper", 1, 2'b01, 0, 12'h022, 32'hFFFF1234, 32'h0, 0, 3);
        chk("half_store_mem_d", r_wd, 32'h1234BEEF);
        run("half_store_readback", 0, 2'b10, 0, 12'h020, 32'h0, 32'h1234BEEF, 0, 2);

        // reset while a half store is in its read phase
        issue(1, 2'b01, 0, 12'h020, 32'h0000ABCD);
        @(negedge clk);
        chk("mid_rmw_ready", req_ready, 0);
        #2 rst = 1;
        mdl[last_idx] = last_old;
        flush();
        @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_resp_valid", resp_valid, 0);
        #2 rst = 0;
        @(negedge clk);
        chk("rst_release_ready", req_ready, 1);
        chk("rst_no_response", resp_valid, 0);
        run("after_reset_load", 0, 2'b10, 0, 12'h020, 32'h0, 32'h1234BEEF, 0, 2);

        pipe_mode = 1;
        run("pipe_clear", 1, 2'b10, 0, 12'h020, 32'h0, 32'h0, 0, 2);
        run("pipe_b2b_store", 1, 2'b10, 0, 12'h020, 32'hDEADBEEF, 32'h0, 0, 2);
        run("pipe_b2b_load", 0, 2'b10, 0, 12'h020, 32'h0, 32'hDEADBEEF, 0, 2);
        run("pipe_byte_rmw", 1, 2'b00, 0, 12'h021, 32'h00000055, 32'h0, 0, 3);
        run("pipe_rmw_readback", 0, 2'b10, 0, 12'h020, 32'h0, 32'hDEAD55EF, 0, 2);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
